// File: rtl/debug_instr_encoder.sv
// debug_instr_encoder: expands high-level debug commands into MIPS32
// instruction words that are fed into the fetch path in debug mode.
// Optional build macro: DEBUG_ENC_SYNC_EN appends a SYNC word to the
// MEMWRITE and MTC0 sequences.
module debug_instr_encoder #(
  parameter int SCRATCH_REG = 27
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [4:0]  cmd_reg,
  input  logic [4:0]  cmd_cp0,
  input  logic [31:0] cmd_data,
  output logic        cmd_err,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic        instr_last,
  output logic        busy
);

  localparam logic [4:0] S_REG = 5'(SCRATCH_REG);

  localparam logic [2:0] OP_LOADIMM  = 3'd0;
  localparam logic [2:0] OP_MEMREAD  = 3'd1;
  localparam logic [2:0] OP_MEMWRITE = 3'd2;
  localparam logic [2:0] OP_MTC0     = 3'd3;
  localparam logic [2:0] OP_MFC0     = 3'd4;
  localparam logic [2:0] OP_NOP      = 3'd5;
  localparam logic [2:0] OP_JUMP     = 3'd6;

  localparam logic [31:0] W_SYNC = 32'h0000_000F;

  typedef enum logic {ST_IDLE, ST_EMIT} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [2:0]  r_op;
  logic [4:0]  r_reg;
  logic [4:0]  r_cp0;
  logic [31:0] r_data;
  logic [1:0]  r_idx;
  logic [1:0]  r_last_idx;
  logic        r_err;

  logic        w_accept;
  logic        w_illegal;
  logic [1:0]  w_in_last_idx;
  logic [15:0] w_hi_adj;
  logic [31:0] w_word;
  logic        w_is_last;

  assign w_accept  = (r_state == ST_IDLE) && cmd_valid;
  assign w_is_last = (r_idx == r_last_idx);
  // Upper half pre-compensated for the sign extension of the low offset.
  assign w_hi_adj  = r_data[31:16] + {15'd0, r_data[15]};

  // Classify the incoming command: legality and index of its final word.
  always_comb begin
    w_illegal     = (cmd_op == 3'd7) || ((cmd_op == OP_MEMWRITE) && (cmd_reg == S_REG));
    w_in_last_idx = 2'd0;
    case (cmd_op)
      OP_LOADIMM: w_in_last_idx = (cmd_data[31:16] == 16'd0) ? 2'd0 : 2'd1;
      OP_MEMREAD: w_in_last_idx = 2'd1;
`ifdef DEBUG_ENC_SYNC_EN
      OP_MEMWRITE: w_in_last_idx = 2'd2;
      OP_MTC0:     w_in_last_idx = 2'd1;
`else
      OP_MEMWRITE: w_in_last_idx = 2'd1;
      OP_MTC0:     w_in_last_idx = 2'd0;
`endif
      OP_JUMP:    w_in_last_idx = 2'd3;
      default:    w_in_last_idx = 2'd0;
    endcase
  end

  // Encode the word selected by the latched command and the word index.
  always_comb begin
    w_word = 32'd0;
    case (r_op)
      OP_LOADIMM: begin
        if (r_last_idx == 2'd0)
          w_word = {6'h0D, 5'd0, r_reg, r_data[15:0]};
        else if (r_idx == 2'd0)
          w_word = {6'h0F, 5'd0, r_reg, r_data[31:16]};
        else
          w_word = {6'h0D, r_reg, r_reg, r_data[15:0]};
      end
      OP_MEMREAD: begin
        if (r_idx == 2'd0) w_word = {6'h0F, 5'd0, S_REG, w_hi_adj};
        else               w_word = {6'h23, S_REG, r_reg, r_data[15:0]};
      end
      OP_MEMWRITE: begin
        if (r_idx == 2'd0)      w_word = {6'h0F, 5'd0, S_REG, w_hi_adj};
        else if (r_idx == 2'd1) w_word = {6'h2B, S_REG, r_reg, r_data[15:0]};
        else                    w_word = W_SYNC;
      end
      OP_MTC0: begin
        if (r_idx == 2'd0) w_word = {6'h10, 5'b00100, r_reg, r_cp0, 11'd0};
        else               w_word = W_SYNC;
      end
      OP_MFC0: w_word = {6'h10, 5'b00000, r_reg, r_cp0, 11'd0};
      OP_NOP:  w_word = 32'd0;
      OP_JUMP: begin
        case (r_idx)
          2'd0:    w_word = {6'h0F, 5'd0, S_REG, r_data[31:16]};
          2'd1:    w_word = {6'h0D, S_REG, S_REG, r_data[15:0]};
          2'd2:    w_word = {6'h00, S_REG, 15'd0, 6'h08};
          default: w_word = 32'd0;
        endcase
      end
      default: w_word = 32'd0;
    endcase
  end

  // Next-state logic: accept a legal command, return to idle after last handshake.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (cmd_valid && !w_illegal) w_state_next = ST_EMIT;
      ST_EMIT: if (instr_ready && w_is_last) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State, command latch, word index and error pulse registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_op       <= OP_NOP;
      r_reg      <= 5'd0;
      r_cp0      <= 5'd0;
      r_data     <= 32'd0;
      r_idx      <= 2'd0;
      r_last_idx <= 2'd0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_err   <= w_accept && w_illegal;
      if (w_accept) begin
        r_op       <= cmd_op;
        r_reg      <= cmd_reg;
        r_cp0      <= cmd_cp0;
        r_data     <= cmd_data;
        r_idx      <= 2'd0;
        r_last_idx <= w_in_last_idx;
      end else if ((r_state == ST_EMIT) && instr_ready) begin
        r_idx <= r_idx + 2'd1;
      end
    end
  end

  assign cmd_ready   = (r_state == ST_IDLE);
  assign instr_valid = (r_state == ST_EMIT);
  assign busy        = (r_state == ST_EMIT);
  assign instr       = instr_valid ? w_word : 32'd0;
  assign instr_last  = instr_valid && w_is_last;
  assign cmd_err     = r_err;

endmodule

// File: doc/debug_instr_encoder.md
Name: debug_instr_encoder

Overview:
- Turns high-level debug commands (load constant into GPR, memory read/write, CP0 move, jump) into encoded MIPS32 instruction word sequences.
- Words are injected into the fetch path while the core is in debug mode, so they pass back through the normal instruction decoder.
- Valid/ready command input; valid/ready instruction output with a last-word marker.

Parameters:
- SCRATCH_REG, 27, GPR used as the address/jump temporary ($k1).

Ports:
- clock  input  1  core clock
- reset  input  1  synchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  encoder can accept a command
- cmd_op  input  3  0 LOADIMM, 1 MEMREAD, 2 MEMWRITE, 3 MTC0, 4 MFC0, 5 NOP, 6 JUMP, 7 reserved
- cmd_reg  input  5  GPR operand (rt/rd)
- cmd_cp0  input  5  CP0 register number
- cmd_data  input  32  immediate value / address / jump target
- cmd_err  output  1  one-cycle pulse: command rejected
- instr_valid  output  1  instr holds a word
- instr_ready  input  1  fetch side consumes the word
- instr  output  32  encoded instruction
- instr_last  output  1  instr is the final word of the sequence
- busy  output  1  sequence in progress (state != IDLE)

Behaviour:
- Reset values: cmd_ready=1, cmd_err=0, instr_valid=0, instr=0, instr_last=0, busy=0. State returns to IDLE.
- States:
  - IDLE: cmd_ready=1. On cmd_valid, latch op/reg/cp0/data. Go to EMIT with index 0, or pulse cmd_err on the next cycle and stay in IDLE.
  - EMIT: cmd_ready=0, instr_valid=1. On instr_valid&&instr_ready, advance index. On the handshake of the last word, go to IDLE. instr_valid drops the next cycle and cmd_ready rises the next cycle.
- Latency: acceptance at cycle T; first word valid at T+1. No bubbles between words when instr_ready stays high.
- Backpressure: while instr_ready=0, instr, instr_last and instr_valid hold stable.
- Address split for memory ops: lo = data[15:0] (sign-extended by hardware); hi_adj = data[31:16] + data[15], modulo 2^16 (0xFFFF+1 wraps to 0x0000).
- Sequences (S = SCRATCH_REG, r = cmd_reg):
  - LOADIMM:
    - if data[31:16]==0: ORI r,$0,data[15:0] (1 word)
    - else: LUI r,data[31:16]; ORI r,r,data[15:0] (2 words)
  - MEMREAD: LUI S,hi_adj; LW r,lo(S).
  - MEMWRITE: LUI S,hi_adj; SW r,lo(S).
  - MTC0: MTC0 r,cp0, sel 0.
  - MFC0: MFC0 r,cp0, sel 0.
  - NOP: 0x00000000.
  - JUMP: LUI S,data[31:16]; ORI S,S,data[15:0]; JR S; NOP (delay slot). Always 4 words.
- Rejection (cmd_err, no words emitted; command still consumed):
  - op 7
  - MEMWRITE with r==S (store data would be clobbered)
  - LOADIMM/MEMREAD/MFC0 with r==0 is legal and is encoded as given.
- Encodings use standard MIPS32 fields: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], imm[15:0].
- Reset mid-sequence: the remaining words are discarded. The next cycle shows IDLE outputs.

Optional Feature:
- Macro DEBUG_ENC_SYNC_EN.
- Defined: MEMWRITE and MTC0 sequences get one extra word, SYNC (0x0000000F). instr_last moves to that word.
- Undefined: no SYNC is appended; sequence lengths are exactly as listed above.

Test Plan:
- LOADIMM r=8 data=0x12345678 -> 0x3C081234, then 0x35085678 (last=1). cmd_ready low for 2 cycles, high on cycle 3.
- LOADIMM r=9 data=0x0000ABCD -> single 0x3409ABCD with last=1. MEMREAD r=4 addr=0x80008004 -> 0x3C1B8001, 0x8F648004. MEMREAD addr=0xFFFF8000 -> first word 0x3C1B0000 (hi_adj wraps).
- JUMP data=0xBFC00000 with instr_ready low for 3 cycles after word 1 -> 0x3C1BBFC0, 0x377B0000 (held stable during stall), 0x03600008, 0x00000000 (last=1).
- MTC0 r=5 cp0=12 -> 0x40856000. With DEBUG_ENC_SYNC_EN: 0x40856000 then 0x0000000F (last only on the second word).
- op=7, then MEMWRITE r=27 -> cmd_err pulses once for each, instr_valid stays 0, cmd_ready stays 1.
- Assert reset during word 2 of JUMP -> next cycle instr_valid=0, busy=0, cmd_ready=1. A following NOP command emits 0x00000000 normally.
